// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised CRT/VGA timing generator. A clock divider derives a pixel
// tick from the system clock. Horizontal and vertical counters step through
// the whole frame in this order: active region, front porch, sync pulse,
// back porch. All outputs are registered and decoded together from the same
// counter snapshot, so they always agree with each other.
//
// Optional feature (compile-time macro):
//   VGA_TIMING_FRAME_CNT_EN - adds the 16-bit output frame_count. It counts
//                             completed frames and is meant as an animation
//                             and sound time base. Leave the macro undefined
//                             to remove the port and its logic.
//
// Ports:
//   CLK          in   system clock
//   RESET        in   asynchronous, active-high reset
//   hsync        out  horizontal sync, asserted level = HS_POL
//   vsync        out  vertical sync, asserted level = VS_POL
//   xposition    out  current pixel column, 0..H_TOTAL-1 (raw count)
//   yposition    out  current line, 0..V_TOTAL-1 (raw count)
//   pix_en       out  one-CLK strobe, once per pixel period
//   active       out  high while inside the visible region
//   line_start   out  one-CLK pulse when xposition first shows 0
//   frame_start  out  one-CLK pulse when the position first shows (0,0)
//   frame_count  out  (macro only) frames since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CNT_W    = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] xposition,
    output logic [CNT_W-1:0] yposition,
    output logic             pix_en,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    // Frame geometry.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The divider needs at least one bit, even when CLK_DIV is 1.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Counter wrap points.
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Region boundaries carry one extra bit. The sync end can equal the
    // total, and the total may fill the whole counter range.
    localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_START  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_START  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    // Asserted sync levels.
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [DIV_W-1:0] r_divCnt;
    logic [CNT_W-1:0] r_hCnt;
    logic [CNT_W-1:0] r_vCnt;
    logic             r_posNew;

    logic             r_hsync;
    logic             r_vsync;
    logic [CNT_W-1:0] r_xPos;
    logic [CNT_W-1:0] r_yPos;
    logic             r_pixEn;
    logic             r_active;
    logic             r_lineStart;
    logic             r_frameStart;

    logic             w_tick;
    logic             w_hLast;
    logic             w_vLast;
    logic [CNT_W:0]   w_hWide;
    logic [CNT_W:0]   w_vWide;
    logic             w_hSyncOn;
    logic             w_vSyncOn;
    logic             w_visible;
    logic             w_lineStart;
    logic             w_frameStart;

    // With CLK_DIV = 1 the divider stays at 0, and 0 equals DIV_LAST.
    // The tick is then permanently high without needing a special case.
    assign w_tick  = (r_divCnt == DIV_LAST);
    assign w_hLast = (r_hCnt == H_LAST);
    assign w_vLast = (r_vCnt == V_LAST);
    assign w_hWide = {1'b0, r_hCnt};
    assign w_vWide = {1'b0, r_vCnt};

    // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps at the tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_divCnt <= '0;
        end else if (w_tick) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    // Raster counters. Both advance only on a pixel tick. The line counter
    // steps when the column counter wraps at the end of a line.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (w_tick) begin
            if (w_hLast) begin
                r_hCnt <= '0;
                if (w_vLast) begin
                    r_vCnt <= '0;
                end else begin
                    r_vCnt <= r_vCnt + 1'b1;
                end
            end else begin
                r_hCnt <= r_hCnt + 1'b1;
            end
        end
    end

    // Marks a counter snapshot that the outputs have not shown yet. The
    // counters only move on a tick, so the snapshot after a tick is new.
    // Reset sets the flag so that the first load after release counts as a
    // fresh (0,0). While the position is held between ticks, the flag stays
    // low and no start pulses repeat.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_posNew <= 1'b1;
        end else begin
            r_posNew <= w_tick;
        end
    end

    // Combinational decode of the current counter snapshot. The vertical
    // sync follows v_cnt only, so it changes exactly when xposition wraps.
    always_comb begin
        w_hSyncOn    = (w_hWide >= HS_START) && (w_hWide < HS_END);
        w_vSyncOn    = (w_vWide >= VS_START) && (w_vWide < VS_END);
        w_visible    = (w_hWide < H_ACT_END) && (w_vWide < V_ACT_END);
        w_lineStart  = r_posNew && (r_hCnt == '0);
        w_frameStart = w_lineStart && (r_vCnt == '0);
    end

    // Output register. Every field loads from the same snapshot on every
    // CLK, so the outputs stay consistent with each other at one CLK of
    // latency. Reset drives the sync lines to their idle levels at once.
    // A sync pulse that is interrupted by reset is not stretched.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hsync      <= ~HS_ON;
            r_vsync      <= ~VS_ON;
            r_xPos       <= '0;
            r_yPos       <= '0;
            r_pixEn      <= 1'b0;
            r_active     <= 1'b0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_hsync      <= w_hSyncOn ? HS_ON : ~HS_ON;
            r_vsync      <= w_vSyncOn ? VS_ON : ~VS_ON;
            r_xPos       <= r_hCnt;
            r_yPos       <= r_vCnt;
            r_pixEn      <= w_tick;
            r_active     <= w_visible;
            r_lineStart  <= w_lineStart;
            r_frameStart <= w_frameStart;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign xposition   = r_xPos;
    assign yposition   = r_yPos;
    assign pix_en      = r_pixEn;
    assign active      = r_active;
    assign line_start  = r_lineStart;
    assign frame_start = r_frameStart;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic        r_frameSeen;
    logic [15:0] r_frameCount;

    // Frame counter. It steps on the same edge that loads frame_start.
    // The first frame after reset is frame 0 and does not step the count.
    // The counter wraps naturally from 0xFFFF to 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frameSeen  <= 1'b0;
            r_frameCount <= 16'd0;
        end else if (w_frameStart) begin
            r_frameSeen <= 1'b1;
            if (r_frameSeen) begin
                r_frameCount <= r_frameCount + 16'd1;
            end
        end
    end

    assign frame_count = r_frameCount;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. It drives two instances:
//   dutA - default 640x480 timing, CLK_DIV = 4, active-low syncs
//   dutB - tiny 14x7 raster, CLK_DIV = 1, active-high syncs, CNT_W = 4
// A closed-form model predicts every output from the number of CLK edges
// since reset release. It pushes predictions into a queue at each rising
// edge. The directed sequence pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic        CLK    = 1'b0;
    logic        resetA = 1'b1;
    logic        resetB = 1'b1;

    logic        hsA, vsA, peA, actA, lsA, fsA;
    logic [9:0]  xA, yA;
    logic        hsB, vsB, peB, actB, lsB, fsB;
    logic [3:0]  xB, yB;
    logic [15:0] fcA, fcB;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HS_POL(0), .VS_POL(0), .CNT_W(10)
    ) dutA (
        .CLK(CLK), .RESET(resetA), .hsync(hsA), .vsync(vsA),
        .xposition(xA), .yposition(yA), .pix_en(peA), .active(actA),
        .line_start(lsA), .frame_start(fsA)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count(fcA)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CNT_W(4)
    ) dutB (
        .CLK(CLK), .RESET(resetB), .hsync(hsB), .vsync(vsB),
        .xposition(xB), .yposition(yB), .pix_en(peB), .active(actB),
        .line_start(lsB), .frame_start(fsB)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count(fcB)
`endif
    );

`ifndef VGA_TIMING_FRAME_CNT_EN
    assign fcA = 16'd0;
    assign fcB = 16'd0;
`endif

    // Closed-form prediction for output edge n after release. Pixel
    // p = n / div is on display. The start pulses belong to the first edge
    // of each pixel period.
    function automatic logic [25:0] modelOut(input int n, input int div,
                                             input int ha, input int hfp, input int hs, input int hbp,
                                             input int va, input int vfp, input int vs, input int vbp,
                                             input logic hpol, input logic vpol);
        int   ht, vt, p, ph, x, y;
        logic oHs, oVs, oAct, oPe, oLs, oFs;
        ht   = ha + hfp + hs + hbp;
        vt   = va + vfp + vs + vbp;
        p    = n / div;
        ph   = n % div;
        x    = p % ht;
        y    = (p / ht) % vt;
        oHs  = (x >= ha + hfp && x < ha + hfp + hs) ? hpol : ~hpol;
        oVs  = (y >= va + vfp && y < va + vfp + vs) ? vpol : ~vpol;
        oAct = (x < ha) && (y < va);
        oPe  = (ph == div - 1);
        oLs  = (x == 0) && (ph == 0);
        oFs  = oLs && (y == 0);
        return {oHs, oVs, oAct, oPe, oLs, oFs, 10'(x), 10'(y)};
    endfunction

    // Number of completed frames at edge n.
    function automatic logic [15:0] modelFc(input int n, input int div, input int frameLen);
        return 16'((n / div) / frameLen);
    endfunction

    int          nA = 0;
    int          nB = 0;
    logic [25:0] qA[$];
    logic [25:0] qB[$];
    logic [15:0] qfA[$];
    logic [15:0] qfB[$];

    always @(posedge CLK or posedge resetA) begin
        if (resetA) begin
            nA <= 0;
            qA.delete();
            qfA.delete();
        end else begin
            qA.push_back(modelOut(nA, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
            qfA.push_back(modelFc(nA, 4, 800 * 525));
            nA <= nA + 1;
        end
    end

    always @(posedge CLK or posedge resetB) begin
        if (resetB) begin
            nB <= 0;
            qB.delete();
            qfB.delete();
        end else begin
            qB.push_back(modelOut(nB, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1));
            qfB.push_back(modelFc(nB, 1, 14 * 7));
            nB <= nB + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one CLK. On the falling edge, compare both instances against
    // either their reset values or the next queued prediction.
    task automatic applyStimulus();
        logic [25:0] obsA, obsB, expV;
        logic [15:0] expF;
        @(negedge CLK);
        obsA = {hsA, vsA, actA, peA, lsA, fsA, xA, yA};
        obsB = {hsB, vsB, actB, peB, lsB, fsB, 6'd0, xB, 6'd0, yB};
        if (resetA) begin
            checkOutput("sbA_reset", {6'd0, obsA}, {6'd0, 2'b11, 24'd0});
        end else if (qA.size() != 0) begin
            expV = qA.pop_front();
            expF = qfA.pop_front();
            checkOutput("sbA", {6'd0, obsA}, {6'd0, expV});
`ifdef VGA_TIMING_FRAME_CNT_EN
            checkOutput("sbA_fc", {16'd0, fcA}, {16'd0, expF});
`endif
        end else begin
            checkOutput("sbA_empty", 32'(qA.size()), 32'd1);
        end
        if (resetB) begin
            checkOutput("sbB_reset", {6'd0, obsB}, 32'd0);
        end else if (qB.size() != 0) begin
            expV = qB.pop_front();
            expF = qfB.pop_front();
            checkOutput("sbB", {6'd0, obsB}, {6'd0, expV});
`ifdef VGA_TIMING_FRAME_CNT_EN
            checkOutput("sbB_fc", {16'd0, fcB}, {16'd0, expF});
`endif
        end else begin
            checkOutput("sbB_empty", 32'(qB.size()), 32'd1);
        end
    endtask

    initial begin
        int   cyc;
        logic done;
        int   peCnt, actCnt, hsLowStrobes, firstHsX, firstIdleX, linePeriod;
        int   lsCnt, hsCnt, vsCnt, firstLsB, firstHsXB, frameLen;

        // Hold both instances in reset for a few clocks.
        resetA = 1'b1;
        resetB = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("rstA_sync", {30'd0, hsA, vsA}, 32'd3);
        checkOutput("rstB_sync", {30'd0, hsB, vsB}, 32'd0);

        // Release both on a falling edge. The first rising edge then loads (0,0).
        resetA = 1'b0;
        resetB = 1'b0;
        applyStimulus();
        checkOutput("firstA_x", {22'd0, xA}, 32'd0);
        checkOutput("firstA_y", {22'd0, yA}, 32'd0);
        checkOutput("firstA_flags", {26'd0, actA, fsA, lsA, hsA, vsA, peA}, {26'd0, 6'b111110});
        checkOutput("firstB_flags", {26'd0, actB, fsB, lsB, hsB, vsB, peB}, {26'd0, 6'b111001});

        // Walk through line 0 of dutA until the next line_start.
        peCnt        = 0;
        actCnt       = 1;
        hsLowStrobes = 0;
        firstHsX     = -1;
        firstIdleX   = -1;
        linePeriod   = 0;
        cyc          = 0;
        done         = 1'b0;
        while (!done && cyc < 4000) begin
            applyStimulus();
            cyc++;
            if (lsA) begin
                done       = 1'b1;
                linePeriod = cyc;
            end else begin
                if (peA) peCnt++;
                if (actA) actCnt++;
                if (peA && !hsA) hsLowStrobes++;
                if (!hsA && firstHsX < 0) firstHsX = int'(xA);
                if (!actA && firstIdleX < 0) firstIdleX = int'(xA);
            end
        end
        checkOutput("lineA_period", 32'(linePeriod), 32'd3200);
        checkOutput("lineA_pixen", 32'(peCnt), 32'd800);
        checkOutput("lineA_active", 32'(actCnt), 32'd2560);
        checkOutput("lineA_hsStrobes", 32'(hsLowStrobes), 32'd96);
        checkOutput("lineA_hsStartX", 32'(firstHsX), 32'd656);
        checkOutput("lineA_idleX", 32'(firstIdleX), 32'd640);
        checkOutput("lineA_y", {22'd0, yA}, 32'd1);

        // Align dutB to a frame_start, then measure one full frame.
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            applyStimulus();
            cyc++;
            if (fsB) done = 1'b1;
        end
        checkOutput("frameB_found", {31'd0, done}, 32'd1);
        peCnt     = int'(peB);
        lsCnt     = int'(lsB);
        hsCnt     = int'(hsB);
        vsCnt     = int'(vsB);
        actCnt    = int'(actB);
        firstLsB  = -1;
        firstHsXB = -1;
        frameLen  = 0;
        cyc       = 0;
        done      = 1'b0;
        while (!done && cyc < 300) begin
            applyStimulus();
            cyc++;
            if (fsB) begin
                done     = 1'b1;
                frameLen = cyc;
            end else begin
                if (peB) peCnt++;
                if (lsB) lsCnt++;
                if (hsB) hsCnt++;
                if (vsB) vsCnt++;
                if (actB) actCnt++;
                if (lsB && firstLsB < 0) firstLsB = cyc;
                if (hsB && firstHsXB < 0) firstHsXB = int'(xB);
            end
        end
        checkOutput("frameB_period", 32'(frameLen), 32'd98);
        checkOutput("frameB_linePeriod", 32'(firstLsB), 32'd14);
        checkOutput("frameB_pixen", 32'(peCnt), 32'd98);
        checkOutput("frameB_lines", 32'(lsCnt), 32'd7);
        checkOutput("frameB_hsHigh", 32'(hsCnt), 32'd14);
        checkOutput("frameB_vsHigh", 32'(vsCnt), 32'd14);
        checkOutput("frameB_active", 32'(actCnt), 32'd32);
        checkOutput("frameB_hsX", 32'(firstHsXB), 32'd10);

        // Reset dutB mid-frame while hsync is asserted, at x=10, y=2.
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            applyStimulus();
            cyc++;
            if (xB == 4'd10 && yB == 4'd2) done = 1'b1;
        end
        checkOutput("midB_reached", {31'd0, done}, 32'd1);
        checkOutput("midB_hsOn", {31'd0, hsB}, 32'd1);
        #2 resetB = 1'b1;
        #1 checkOutput("midB_async", {18'd0, hsB, vsB, actB, peB, lsB, fsB, xB, yB}, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus();
        resetB = 1'b0;
        applyStimulus();
        checkOutput("midB_restart", {18'd0, fsB, lsB, actB, peB, hsB, vsB, xB, yB}, {18'd0, 6'b111100, 8'd0});

        // Reset dutA mid-line at x=300, then restart at (0,0).
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 4000) begin
            applyStimulus();
            cyc++;
            if (xA == 10'd300) done = 1'b1;
        end
        checkOutput("midA_reached", {31'd0, done}, 32'd1);
        #2 resetA = 1'b1;
        #1 checkOutput("midA_async", {6'd0, hsA, vsA, actA, peA, lsA, fsA, xA, yA}, {6'd0, 2'b11, 24'd0});
        for (int i = 0; i < 3; i++) applyStimulus();
        resetA = 1'b0;
        applyStimulus();
        checkOutput("midA_restart", {6'd0, fsA, lsA, actA, peA, hsA, vsA, xA, yA}, {6'd0, 6'b111011, 20'd0});
        for (int i = 0; i < 20; i++) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
